// File: rtl/decoder_grant_arbiter.sv
// decoder_grant_arbiter
// Round-robin arbiter that turns four request lines into the addr1/addr0/enable
// triple for a 2-to-4 decoder. A grant is held until done, until the grantee
// drops its request, or until HOLD_MAX cycles have elapsed. Consecutive grants
// are always separated by one cycle with enable low.
//
// Handshake: req[i] is a level request and is sampled only in IDLE, except for
// the current grantee's line, which is watched every grant cycle. done is a
// one-cycle release strobe from the grantee and is ignored outside a grant.
// All outputs are flops; nothing combinational reaches the ports.
module decoder_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 4  // legal range 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic       addr0,
    output logic       addr1,
    output logic       enable,
    output logic       grant_timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter value seen on the last cycle of a full-length grant.
    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;       // first index searched in the next IDLE
    logic [7:0] cnt_q, cnt_d;       // grant cycles elapsed, saturating
    logic [1:0] addr_q, addr_d;     // current / last grantee
    logic       enable_q, enable_d;
    logic       timeout_q, timeout_d;

    logic       rel_done;
    logic       rel_drop;
    logic       rel_time;

    // Rotating priority search starting at p; returns p when nothing is set.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + i[1:0];
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Release causes for the active grant; only meaningful in ST_GRANT.
    always_comb begin
        rel_done = done;
        rel_drop = ~req[addr_q];
        rel_time = (cnt_q == CNT_LAST);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        enable_d  = enable_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                enable_d = 1'b0;
                if (req != 4'b0000) begin
                    addr_d   = rr_pick(req, ptr_q);
                    cnt_d    = 8'd0;
                    enable_d = 1'b1;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_time) begin
                    state_d   = ST_IDLE;
                    enable_d  = 1'b0;
                    ptr_d     = addr_q + 2'd1;
                    cnt_d     = 8'd0;
                    // Timeout is flagged only when expiry was the sole cause.
                    timeout_d = rel_time && !rel_done && !rel_drop;
                end else begin
                    enable_d = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                enable_d = 1'b0;
                cnt_d    = 8'd0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            addr_q    <= 2'd0;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
        end
    end

    assign addr0         = addr_q[0];
    assign addr1         = addr_q[1];
    assign enable        = enable_q;
    assign grant_timeout = timeout_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Bench for decoder_grant_arbiter (HOLD_MAX = 4). Stimulus pushes one expected
// grant record per grant; a negedge monitor rebuilds each observed grant
// (address, address stability, length, timeout pulse) and pops to compare.
module tb_decoder_grant_arbiter;

  localparam int RW = 12;  // {stable, addr[1:0], len[7:0], timeout}

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       addr0;
  logic       addr1;
  logic       enable;
  logic       grant_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] exp_q[$];

  decoder_grant_arbiter #(.HOLD_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .addr0        (addr0),
    .addr1        (addr1),
    .enable       (enable),
    .grant_timeout(grant_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  // driver tasks
  task automatic expect_grant(input logic [1:0] a, input int len, input logic to);
    exp_q.push_back({1'b1, a, 8'(len), to});
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic wait_enable(input string name);
    int b;
    b = 0;
    while (enable !== 1'b1 && b < 50) begin
      tick();
      b++;
    end
    if (enable !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: enable stayed %b for 50 cycles, required 1", name, enable);
    end
  endtask

  task automatic wait_disable(input string name);
    int b;
    b = 0;
    while (enable !== 1'b0 && b < 50) begin
      tick();
      b++;
    end
    if (enable !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: enable stayed %b for 50 cycles, required 0", name, enable);
    end
  endtask

  // Called in grant cycle 1; asserts done during grant cycle n.
  task automatic hold_done(input int n);
    repeat (n - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic          prev_en;
    logic          stable;
    logic [1:0]    cur_addr;
    int            len;
    logic [RW-1:0] got;
    logic [RW-1:0] exp;
    prev_en  = 1'b0;
    stable   = 1'b1;
    cur_addr = 2'd0;
    len      = 0;
    forever begin
      @(negedge clk);
      if (enable === 1'b1) begin
        if (!prev_en) begin
          cur_addr = {addr1, addr0};
          stable   = 1'b1;
          len      = 0;
        end else if ({addr1, addr0} !== cur_addr) begin
          stable = 1'b0;
        end
        len++;
      end else if (prev_en) begin
        got = {stable, cur_addr, 8'(len), grant_timeout};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got stable=%0b addr=%0d len=%0d timeout=%0b, required no grant",
                   got[11], got[10:9], got[8:1], got[0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL grant: got stable=%0b addr=%0d len=%0d timeout=%0b, required stable=%0b addr=%0d len=%0d timeout=%0b",
                     got[11], got[10:9], got[8:1], got[0], exp[11], exp[10:9], exp[8:1], exp[0]);
          end
        end
      end else if (grant_timeout !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_timeout: got grant_timeout=%b outside release cycle, required 0", grant_timeout);
      end
      prev_en = (enable === 1'b1);
    end
  end

  // watchdog
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // directed stimulus
  initial begin
    // 1: reset with all requests high, no clock edge yet
    reset = 1'b1;
    req   = 4'b1111;
    done  = 1'b0;
    #2;
    check("reset_enable", 8'(enable), 8'd0);
    check("reset_addr0", 8'(addr0), 8'd0);
    check("reset_addr1", 8'(addr1), 8'd0);
    check("reset_timeout", 8'(grant_timeout), 8'd0);
    req = 4'b0000;
    tick();
    reset = 1'b0;
    tick();

    // 2: single grant to 2, done in grant cycle 3
    expect_grant(2'd2, 3, 1'b0);
    req = 4'b0100;
    wait_enable("t2_grant");
    check("t2_addr", 8'({addr1, addr0}), 8'd2);
    hold_done(3);
    req = 4'b0000;
    check("t2_enable_after", 8'(enable), 8'd0);
    check("t2_timeout_after", 8'(grant_timeout), 8'd0);

    // 3: rotation 0,1,2,3,0 from a fresh pointer
    do_reset();
    for (int i = 0; i < 5; i++) expect_grant(2'(i % 4), 1, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_enable("t3_grant");
      hold_done(1);
    end
    req = 4'b0000;

    // 4: timeout on a held request, then re-grant of the same requester
    expect_grant(2'd1, 4, 1'b1);
    expect_grant(2'd1, 2, 1'b0);
    req = 4'b0010;
    wait_enable("t4_grant");
    wait_disable("t4_release");
    check("t4_timeout_pulse", 8'(grant_timeout), 8'd1);
    check("t4_enable_low", 8'(enable), 8'd0);
    wait_enable("t4_regrant");
    check("t4_regrant_addr", 8'({addr1, addr0}), 8'd1);
    hold_done(2);
    req = 4'b0000;

    // 5a: done coincides with expiry -> normal release
    expect_grant(2'd0, 4, 1'b0);
    req = 4'b0001;
    wait_enable("t5a_grant");
    hold_done(4);
    check("t5a_timeout", 8'(grant_timeout), 8'd0);

    // 5b: ptr=1, req=1001 -> 3 then 0; req[0] dropped mid-grant of 0
    expect_grant(2'd3, 1, 1'b0);
    expect_grant(2'd0, 2, 1'b0);
    expect_grant(2'd3, 1, 1'b0);
    req = 4'b1001;
    wait_enable("t5b_grant3");
    check("t5b_first_addr", 8'({addr1, addr0}), 8'd3);
    hold_done(1);
    wait_enable("t5b_grant0");
    check("t5b_second_addr", 8'({addr1, addr0}), 8'd0);
    tick();
    req = 4'b1000;
    tick();
    check("t5b_drop_release", 8'(enable), 8'd0);
    check("t5b_drop_timeout", 8'(grant_timeout), 8'd0);
    wait_enable("t5b_grant3b");
    check("t5b_third_addr", 8'({addr1, addr0}), 8'd3);
    hold_done(1);
    req = 4'b0000;

    // 5c: request drop coincides with expiry -> normal release
    expect_grant(2'd2, 4, 1'b0);
    req = 4'b0100;
    wait_enable("t5c_grant");
    repeat (3) tick();
    req = 4'b0000;
    tick();
    check("t5c_enable", 8'(enable), 8'd0);
    check("t5c_timeout", 8'(grant_timeout), 8'd0);

    // 6: asynchronous reset mid-grant, then first search from ptr=0
    do_reset();
    req = 4'b0011;
    wait_enable("t6_grant");
    check("t6_grant_addr", 8'({addr1, addr0}), 8'd0);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_enable", 8'(enable), 8'd0);
    check("t6_async_addr", 8'({addr1, addr0}), 8'd0);
    check("t6_async_timeout", 8'(grant_timeout), 8'd0);
    req = 4'b1000;
    #2;
    reset = 1'b0;
    expect_grant(2'd3, 1, 1'b0);
    tick();
    check("t6_regrant_enable", 8'(enable), 8'd1);
    check("t6_regrant_addr", 8'({addr1, addr0}), 8'd3);
    hold_done(1);
    req = 4'b0000;

    repeat (3) tick();
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Round-robin arbiter that turns four request lines into the `addr0`/`addr1`/`enable` triple consumed by the 2-to-4 decoder. It sits directly upstream of the decoder, so exactly one decoder output is active per grant. Each grant is held until the requester signals done, drops its request, or a hold timeout expires. Between grants there is always one idle cycle with `enable` low, so the decoder outputs are all false in that cycle.

## Interface
- `HOLD_MAX`, default 4: maximum number of consecutive cycles a grant may stay active before forced release. Legal values are 1 to 255.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  4: request lines. `req[i]` asks for decoder output i.
- `done`  in  1: the current grantee releases its grant. Ignored in IDLE.
- `addr0`  out  1: registered address LSB to the decoder.
- `addr1`  out  1: registered address MSB to the decoder.
- `enable`  out  1: registered decoder enable. High only in GRANT.
- `grant_timeout`  out  1: registered one-cycle pulse when a grant was ended by `HOLD_MAX` expiry.

## Operation
- **Reset values:** `addr0`=0, `addr1`=0, `enable`=0, `grant_timeout`=0. Internally, rotation pointer `ptr`=0, hold counter `cnt`=0, state=IDLE.
- **Address encoding:** grantee g maps to {`addr1`,`addr0`} = g[1:0]. So `addr0`=1, `addr1`=0 selects output 1.
- **IDLE:**
  - `enable`=0.
  - If `req`≠0, search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first asserted one as g.
  - Register the address for g, set `cnt`=0, and go to GRANT.
  - If `req`=0, stay in IDLE. The address outputs hold their last value.
- **GRANT:**
  - `enable`=1. The address is stable for the whole grant.
  - Each cycle, `cnt` increments (8-bit counter, saturating; it never wraps).
  - Release conditions, checked at each rising edge:
    - (a) `done`=1
    - (b) `req[g]`=0
    - (c) `cnt`=`HOLD_MAX`-1, i.e. the grant has been active for `HOLD_MAX` cycles.
  - On any release: go to IDLE, set ptr=(g+1) mod 4 (2-bit wrap), clear `cnt`.
  - Priority: if (c) coincides with (a) or (b), the release is a normal one and `grant_timeout` stays 0. `grant_timeout`=1 only when (c) alone caused the release.
- **Fairness:** a requester that keeps `req` high after a timeout is eligible again, but only after every other pending requester has been served once.
- **`done` in IDLE:** no effect.
- **`req` changes mid-grant:** changes on non-grantee lines have no effect until the next IDLE search.

## Timing
- **Grant latency:** `req` sampled high at edge k (state IDLE) gives `enable`=1 and a valid address after edge k. That is 1 cycle of latency.
- **Release latency:** a release condition true at edge k gives `enable`=0 after edge k. `grant_timeout` is high for exactly the cycle after edge k.
- **Minimum gap:** 1 cycle with `enable` low between consecutive grants, even when requests are continuously pending.
- **Back-to-back throughput:** one grant per (hold + 1) cycles.
- **Reset mid-grant:** `enable` and the address go to 0 immediately, without waiting for `clk`. After `reset` deasserts, the first search starts at ptr=0.
- **Output quality:** all outputs come from flops, with no combinational path from `req`/`done` to any output.

## Test plan
1. **Reset:** assert `reset` with `req`=4'b1111 → `enable`=0, `addr0`=0, `addr1`=0, `grant_timeout`=0 while `reset` is high, with no clock edge required.
2. **Single grant:** `req`=4'b0100 from IDLE, `done` pulsed on the 3rd grant cycle → one cycle later `enable`=1, `addr1`=1, `addr0`=0 for 3 cycles, then `enable`=0. `grant_timeout` stays 0.
3. **Rotation:** `req`=4'b1111 held, `done` pulsed on the 1st cycle of every grant → addresses 0,1,2,3,0 in turn, each grant followed by a 1-cycle `enable`-low gap.
4. **Timeout:** `HOLD_MAX`=4, `req`=4'b0010 held, `done`=0 → `enable` high for exactly 4 cycles, then `grant_timeout`=1 for 1 cycle with `enable`=0. After that, address 1 is re-granted.
5. **Simultaneous release:** `done`=1 on the 4th grant cycle with `HOLD_MAX`=4 → grant ends and `grant_timeout` stays 0. Separately, with `req`=4'b1001, ptr=1 and `req[0]` dropped mid-grant: grant 3 first, then 0.
6. **Reset mid-grant:** `req`=4'b0011, grant to 0 active, pulse `reset` between clock edges → `enable` falls immediately. After release with `req`=4'b1000, the next grant is address 3 (`addr0`=1, `addr1`=1) one cycle later.
